if_id_buffer: RTL
=================

IF_ID_BUFFER -- requirements
Module: if_id_buffer

Interface
REQ-001 SHALL provide parameter DEPTH, default 2: entry count; power of two, >= 2.
REQ-002 SHALL provide parameter NOP, default 32'h00000013: instruction presented when empty (addi x0,x0,0).
REQ-003 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port flush  input  1  synchronous discard of all entries (taken branch/jump).
REQ-006 SHALL have port in_valid  input  1  fetch side offers an entry.
REQ-007 SHALL have port in_ready  output  1  buffer accepts an entry this cycle.
REQ-008 SHALL have port in_pc  input  32  fetched instruction address.
REQ-009 SHALL have port in_pc4  input  32  fetched address + 4.
REQ-010 SHALL have port in_inst  input  32  fetched instruction word.
REQ-011 SHALL have port out_valid  output  1  head entry valid for decode.
REQ-012 SHALL have port out_ready  input  1  decode consumes head this cycle.
REQ-013 SHALL have port out_pc  output  32  head entry address.
REQ-014 SHALL have port out_pc4  output  32  head entry address + 4.
REQ-015 SHALL have port out_inst  output  32  head entry instruction.
REQ-016 SHALL have port count  output  $clog2(DEPTH)+1  occupied entries.

Function
REQ-017 SHALL store {pc, pc4, inst} per entry in a circular buffer with read pointer, write pointer and count.
REQ-018 SHALL push on a rising edge when in_valid && in_ready && !flush; write pointer advances, wrapping DEPTH-1 -> 0.
REQ-019 SHALL pop on a rising edge when out_valid && out_ready && !flush; read pointer advances, wrapping DEPTH-1 -> 0.
REQ-020 SHALL drive in_ready = (count != DEPTH); combinational from registered count only, no dependence on out_ready.
REQ-021 SHALL drive out_valid = (count != 0); out_* come from the head entry registers (show-ahead); no input-to-output combinational path.
REQ-022 SHALL give minimum latency 1 cycle: an entry pushed at edge N is visible on out_* after edge N.
REQ-023 SHALL, on simultaneous push and pop with 0 < count < DEPTH, leave count unchanged and advance both pointers.
REQ-024 SHALL, when full, refuse push (in_ready=0) even if a pop occurs that cycle; in_ready rises the cycle after the pop.
REQ-025 SHALL, when empty, ignore out_ready; out_pc=0, out_pc4=0, out_inst=NOP.
REQ-026 SHALL treat flush as dominant: on an edge with flush=1, count and both pointers clear to 0; a simultaneous push or pop has no effect.
REQ-027 SHALL keep entry storage unchanged by flush; only pointers/count clear.
REQ-028 SHALL keep count within 0..DEPTH under all input sequences; in_valid with in_ready=0 has no effect.

Reset
REQ-029 SHALL, when reset=0, asynchronously clear count, read and write pointers to 0, independent of clk.
REQ-030 SHALL present during and after reset: out_valid=0, in_ready=1, count=0, out_pc=0, out_pc4=0, out_inst=NOP.
REQ-031 SHALL discard in-flight entries when reset asserts mid-operation; first push after release lands at index 0.
REQ-032 SHALL need no reset on entry storage.

Verification
REQ-033 Push pc=0x0, inst=0x00500093, out_ready=0 -> next cycle out_valid=1, out_pc=0x0, out_pc4=0x4, out_inst=0x00500093, count=1.
REQ-034 DEPTH=2: push pc=0x0, 0x4, 0x8 consecutively, out_ready=0 -> count=2, in_ready=0 after second push, third entry dropped; drain gives 0x0 then 0x4.
REQ-035 count=1, push pc=0x8 and pop same cycle -> count=1, out_pc=0x8 next cycle; repeat 5 times, pointers wrap, order preserved.
REQ-036 count=2, flush=1 with in_valid=1 and out_ready=1 -> next cycle count=0, out_valid=0, out_inst=0x00000013; following push pc=0x40 appears alone at head.
REQ-037 count=2, reset=0 between clock edges -> count=0, out_valid=0, in_ready=1 immediately; after release push pc=0x100 -> out_pc=0x100.

Source files
------------

// File: rtl/if_id_buffer.sv
// IF/ID pipeline buffer: small circular FIFO of {pc, pc4, inst} with show-ahead head output.
// Empty buffer presents a NOP bubble; flush discards contents without touching storage.
module if_id_buffer #(
   parameter int unsigned DEPTH = 2,
   parameter logic [31:0] NOP   = 32'h00000013
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     flush,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [31:0]              in_pc,
   input  logic [31:0]              in_pc4,
   input  logic [31:0]              in_inst,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [31:0]              out_pc,
   output logic [31:0]              out_pc4,
   output logic [31:0]              out_inst,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int unsigned PW = $clog2(DEPTH);
   localparam int unsigned CW = PW + 1;

   logic [PW-1:0] rd_ptr_q, rd_ptr_d;
   logic [PW-1:0] wr_ptr_q, wr_ptr_d;
   logic [CW-1:0] count_q, count_d;

   logic [31:0] pc_q   [DEPTH];
   logic [31:0] pc4_q  [DEPTH];
   logic [31:0] inst_q [DEPTH];

   logic push, pop;

   // Handshakes depend only on registered count, so no input reaches an output combinationally.
   always_comb begin
      in_ready  = (count_q != CW'(DEPTH));
      out_valid = (count_q != '0);
      push      = in_valid && in_ready && !flush;
      pop       = out_valid && out_ready && !flush;
   end

   // DEPTH is a power of two, so pointer overflow is the wrap DEPTH-1 -> 0.
   always_comb begin
      rd_ptr_d = rd_ptr_q;
      wr_ptr_d = wr_ptr_q;
      count_d  = count_q;
      if (flush) begin
         rd_ptr_d = '0;
         wr_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (push) wr_ptr_d = wr_ptr_q + PW'(1);
         if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
         unique case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         rd_ptr_q <= rd_ptr_d;
         wr_ptr_q <= wr_ptr_d;
         count_q  <= count_d;
      end
   end

   // Entry storage carries no reset; validity is tracked solely by count.
   always_ff @(posedge clk) begin
      if (push) begin
         pc_q[wr_ptr_q]   <= in_pc;
         pc4_q[wr_ptr_q]  <= in_pc4;
         inst_q[wr_ptr_q] <= in_inst;
      end
   end

   always_comb begin
      out_pc   = '0;
      out_pc4  = '0;
      out_inst = NOP;
      if (out_valid) begin
         out_pc   = pc_q[rd_ptr_q];
         out_pc4  = pc4_q[rd_ptr_q];
         out_inst = inst_q[rd_ptr_q];
      end
   end

   assign count = count_q;

endmodule
